// File: rtl/aes_pkg.sv
// Shared AES field constants and helpers for the S-box paths.
// GF(2^4) uses x^4+x+1; GF(2^8) is built as GF(2^4)[Y]/(Y^2+Y+lambda).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sb_state_t;

  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [3:0] GF4_LAMBDA   = 4'hC;

  // Column j holds the image of input bit j.
  typedef logic [7:0][7:0] bit_mat_t;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  function automatic logic [3:0] gf4_sq_scale(input logic [3:0] a);
    return gf4_mul(GF4_LAMBDA, gf4_sq(a));
  endfunction

  // a^14 is the inverse for a != 0 and leaves 0 at 0.
  function automatic logic [3:0] gf4_pow14(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] mat_apply(input bit_mat_t m, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (v[j]) r = r ^ m[j];
    end
    return r;
  endfunction

  // Composite -> AES basis: low nibble bit i maps to w^i, high nibble bit i to Y*w^i,
  // where w is a root of x^4+x+1 and Y a root of Y^2+Y+lambda, both found in GF(2^8).
  function automatic bit_mat_t build_iso_inv();
    bit_mat_t         m;
    logic [3:0][7:0]  pw;
    logic [7:0]       omega, y, lam, p;
    logic             found_w, found_y;
    m = '0; omega = '0; y = '0; found_w = 1'b0; found_y = 1'b0;
    for (int v = 2; v < 256; v++) begin
      p = 8'(v);
      if (!found_w && ((gf8_mul(gf8_mul(gf8_mul(p, p), p), p) ^ p) == 8'h01)) begin
        omega   = p;
        found_w = 1'b1;
      end
    end
    pw[0] = 8'h01;
    for (int i = 1; i < 4; i++) pw[i] = gf8_mul(pw[i-1], omega);
    lam = '0;
    for (int i = 0; i < 4; i++) begin
      if (GF4_LAMBDA[i]) lam = lam ^ pw[i];
    end
    for (int v = 2; v < 256; v++) begin
      p = 8'(v);
      if (!found_y && ((gf8_mul(p, p) ^ p) == lam)) begin
        y       = p;
        found_y = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m[i]   = pw[i];
      m[i+4] = gf8_mul(y, pw[i]);
    end
    return m;
  endfunction

  function automatic bit_mat_t build_iso_fwd(input bit_mat_t inv);
    bit_mat_t   m;
    logic [7:0] img;
    m = '0;
    for (int c = 0; c < 256; c++) begin
      img = mat_apply(inv, 8'(c));
      for (int i = 0; i < 8; i++) begin
        if (img == (8'h01 << i)) m[i] = 8'(c);
      end
    end
    return m;
  endfunction

  localparam bit_mat_t ISO_INV = build_iso_inv();
  localparam bit_mat_t ISO_FWD = build_iso_fwd(ISO_INV);

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/aes_inv_subbytes_if.sv
// State-in / state-out handshake bundle for the InvSubBytes engine.
// A transfer happens on a rising edge where valid && ready; the sender holds data while valid is high and ready is low.
interface aes_inv_subbytes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (output in_valid, in_state, out_ready,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, out_ready,
                  output in_ready, out_valid, out_state);
endinterface

// File: rtl/aes_inv_sbox_byte.sv
// Combinational inverse S-box for one byte: inverse affine, then inversion in GF((2^4)^2).
module aes_inv_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  logic [7:0] aff, comp;
  logic [3:0] ah, al, hl, norm, norm_inv, oh, ol;

  assign aff  = inv_affine(byte_i);
  assign comp = mat_apply(ISO_FWD, aff);
  assign ah   = comp[7:4];
  assign al   = comp[3:0];

  spem u_hl (.a_i(ah), .b_i(al), .p_o(hl));

  // Norm of ah*Y+al against its conjugate ah*(Y+1)+al.
  assign norm = gf4_sq_scale(ah) ^ hl ^ gf4_sq(al);

  gf4_inv u_inv (.a_i(norm), .a_inv_o(norm_inv));

  spem u_oh (.a_i(ah),      .b_i(norm_inv), .p_o(oh));
  spem u_ol (.a_i(ah ^ al), .b_i(norm_inv), .p_o(ol));

  assign byte_o = mat_apply(ISO_INV, {oh, ol});
endmodule

// File: rtl/gf4_inv.sv
// GF(2^4) multiplicative inverse with 0 mapping to 0.
module gf4_inv
  import aes_pkg::*;
(
  input  logic [3:0] a_i,
  output logic [3:0] a_inv_o
);
  assign a_inv_o = gf4_pow14(a_i);
endmodule

// File: rtl/spem.sv
// GF(2^4) multiplier, polynomial basis, modulus x^4+x+1.
module spem
  import aes_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] p_o
);
  assign p_o = gf4_mul(a_i, b_i);
endmodule

// File: rtl/aes_inv_subbytes.sv
// Iterative InvSubBytes: BYTES_PER_CYCLE parallel inverse S-boxes sweep a 128-bit state lowest chunk first.
module aes_inv_subbytes
  import aes_pkg::*;
#(
  parameter  int BYTES_PER_CYCLE = 4,
  localparam int N     = 16 / BYTES_PER_CYCLE,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  aes_inv_subbytes_if.slave  bus,
  output inv_sb_state_t      dbg_state_o,
  output logic [CNT_W-1:0]   dbg_cnt_o
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("aes_inv_subbytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  inv_sb_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     work_q, work_d;
  logic [7:0]       sb_in  [BYTES_PER_CYCLE];
  logic [7:0]       sb_out [BYTES_PER_CYCLE];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    aes_inv_sbox_byte u_sbox (.byte_i(sb_in[g]), .byte_o(sb_out[g]));
  end

  always_comb begin
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      sb_in[g] = work_q[8*(int'(cnt_q)*BYTES_PER_CYCLE + g) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
          work_d[8*(int'(cnt_q)*BYTES_PER_CYCLE + g) +: 8] = sb_out[g];
        end
        // cnt holds at N-1 through DONE and is cleared on the next accept.
        if (int'(cnt_q) == N - 1) state_d = DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = work_q;
  assign dbg_state_o   = state_q;
  assign dbg_cnt_o     = cnt_q;

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Bench for aes_inv_subbytes: one instance per BYTES_PER_CYCLE value, driven in lockstep,
// each with its own expected-result queue fed from a table-based inverse S-box reference.
module tb_aes_inv_subbytes;
  import aes_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         in_valid  = 1'b0;
  logic [127:0] in_state  = '0;
  logic         out_ready = 1'b1;
  bit           b2b       = 1'b0;
  logic [4:0]   rdy_vec;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] inv_tbl [256];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[s[8*i +: 8]];
    return r;
  endfunction

  task automatic build_ref_table();
    logic [7:0] inv, sb;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tbl[sb] = 8'(x);
    end
  endtask

  // DUT instances and per-instance scoreboards
  for (genvar k = 0; k < 5; k++) begin : g_dut
    localparam int BPC = 1 << k;
    localparam int N   = 16 / BPC;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;

    aes_inv_subbytes_if bus ();
    inv_sb_state_t      dbg_state;
    logic [CW-1:0]      dbg_cnt;

    assign bus.in_valid  = in_valid;
    assign bus.in_state  = in_state;
    assign bus.out_ready = out_ready;
    assign rdy_vec[k]    = bus.in_ready;

    aes_inv_subbytes #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_cnt_o   (dbg_cnt)
    );

    logic [127:0] exp_q[$];
    int acc_cyc  = 0;
    int last_acc = -1;
    bit seen_valid = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        seen_valid = 1'b0;
        last_acc   = -1;
      end else begin
        if (bus.out_valid && !seen_valid) begin
          check_eq($sformatf("latency_bpc%0d", BPC), 128'(cyc - acc_cyc - 1), 128'(N));
          seen_valid = 1'b1;
        end
        if (!bus.out_valid) seen_valid = 1'b0;
        if (bus.out_valid && out_ready) begin
          check_eq($sformatf("occupancy_bpc%0d", BPC), 128'(exp_q.size()), 128'(1));
          if (exp_q.size() > 0)
            check_eq($sformatf("result_bpc%0d", BPC), bus.out_state, exp_q.pop_front());
        end
        if (in_valid && bus.in_ready) begin
          exp_q.push_back(ref_state(in_state));
          if (b2b && last_acc >= 0)
            check_eq($sformatf("spacing_bpc%0d", BPC), 128'(cyc - last_acc), 128'(N + 2));
          last_acc = b2b ? cyc : -1;
          acc_cyc  = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_all_idle();
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (rdy_vec !== 5'h1f && t < 200);
    if (rdy_vec !== 5'h1f) check_eq("idle_timeout", 128'(rdy_vec), 128'(5'h1f));
  endtask

  task automatic drive_one(input logic [127:0] s);
    int t = 0;
    while (rdy_vec !== 5'h1f && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (rdy_vec !== 5'h1f) check_eq("drive_timeout", 128'(rdy_vec), 128'(5'h1f));
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_main_valid();
    int t = 0;
    while (g_dut[2].bus.out_valid !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (g_dut[2].bus.out_valid !== 1'b1) check_eq("valid_timeout", 128'(g_dut[2].bus.out_valid), 128'(1));
  endtask

  task automatic run_held(input string tag, input logic [127:0] s, input logic [127:0] exp);
    out_ready = 1'b0;
    drive_one(s);
    wait_main_valid();
    check_eq(tag, g_dut[2].bus.out_state, exp);
    out_ready = 1'b1;
    wait_all_idle();
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] s, s2;
    int acc, t;
    bit main_acc;

    build_ref_table();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  128'(g_dut[2].bus.in_ready),  128'(1));
    check_eq("rst_out_valid", 128'(g_dut[2].bus.out_valid), 128'(0));
    check_eq("rst_out_state", g_dut[2].bus.out_state,       128'h0);
    check_eq("rst_fsm_state", 128'(g_dut[2].dbg_state),     128'(IDLE));
    rst = 1'b0;

    run_held("all_63", {16{8'h63}}, 128'h0);
    run_held("known_vec", {{12{8'h63}}, 8'hED, 8'h16, 8'h7C, 8'h00},
                          {{12{8'h00}}, 8'h53, 8'hFF, 8'h01, 8'h52});

    // backpressure with an ignored in_valid pulse
    s = rand_state();
    out_ready = 1'b0;
    drive_one(s);
    wait_main_valid();
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold_state", g_dut[2].bus.out_state, ref_state(s));
      check_eq("bp_in_ready",   128'(g_dut[2].bus.in_ready), 128'(0));
      if (i == 4) begin
        in_state = ~s;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_in_ready",  128'(g_dut[2].bus.in_ready),  128'(1));
    check_eq("bp_release_out_valid", 128'(g_dut[2].bus.out_valid), 128'(0));
    wait_all_idle();

    // every byte value once
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16*j + i);
      drive_one(s);
    end
    wait_all_idle();

    // back-to-back with in_valid held high
    b2b = 1'b1;
    in_state = rand_state();
    in_valid = 1'b1;
    acc = 0;
    t = 0;
    while (acc < 6 && t < 200) begin
      main_acc = g_dut[2].bus.in_ready;
      @(posedge clk); #1;
      t++;
      if (main_acc) begin
        acc++;
        in_state = rand_state();
      end
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    check_eq("b2b_accepts", 128'(acc), 128'(6));
    wait_all_idle();

    // reset in the middle of BUSY
    s = rand_state();
    drive_one(s);
    t = 0;
    while (!(g_dut[2].dbg_cnt == 2 && g_dut[2].dbg_state == BUSY) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("mr_cnt_reached", 128'(g_dut[2].dbg_cnt), 128'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mr_out_valid", 128'(g_dut[2].bus.out_valid), 128'(0));
    check_eq("mr_in_ready",  128'(g_dut[2].bus.in_ready),  128'(1));
    check_eq("mr_out_state", g_dut[2].bus.out_state,       128'h0);
    check_eq("mr_cnt",       128'(g_dut[2].dbg_cnt),       128'(0));
    rst = 1'b0;
    s2 = rand_state();
    run_held("mr_next_state", s2, ref_state(s2));

    repeat (3) @(posedge clk);
    #1;
    check_eq("drain_bpc1",  128'(g_dut[0].exp_q.size()), 128'(0));
    check_eq("drain_bpc2",  128'(g_dut[1].exp_q.size()), 128'(0));
    check_eq("drain_bpc4",  128'(g_dut[2].exp_q.size()), 128'(0));
    check_eq("drain_bpc8",  128'(g_dut[3].exp_q.size()), 128'(0));
    check_eq("drain_bpc16", 128'(g_dut[4].exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_subbytes.md
# aes_inv_subbytes

Iterative AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit state, applies the inverse S-box to every byte, and returns the result. The inverse S-box is computed rather than looked up: inverse affine transform, then GF(2^8) inversion in the composite field GF((2^4)^2), then the inverse isomorphism. It reuses the team's GF(2^4) multiplier `spem` and shares field constants with the forward SubBytes path.

## Interface

Parameters:
- `BYTES_PER_CYCLE`, default 4: bytes transformed per busy cycle.
  - Legal values: 1, 2, 4, 8, 16.
  - Any other value is an elaboration error.

Ports:
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: `in_state` is valid.
- `in_ready`  out  1: block can accept a state.
- `in_state`  in  128: ciphertext-side state; byte i = `in_state[8i+7:8i]`.
- `out_valid`  out  1: `out_state` holds a finished result.
- `out_ready`  in  1: downstream accepts the result.
- `out_state`  out  128: InvSubBytes(`in_state`), same byte order.

## Operation

- Let N = 16 / `BYTES_PER_CYCLE`.
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: a chunk counter `cnt` runs 0..N-1.
  - DONE: `out_valid`=1.
- IDLE → BUSY on `in_valid && in_ready`:
  - load `in_state` into the working register;
  - clear `cnt` to 0.
- BUSY, each cycle:
  - replace bytes `cnt*BYTES_PER_CYCLE` .. `cnt*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1` with their inverse S-box values;
  - increment `cnt`.
  - On the edge that processes chunk N-1, go to DONE.
  - Chunks are processed lowest first; `cnt` never wraps past N-1.
- DONE:
  - `out_state` = working register, held stable while `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- Per-byte transform:
  - inverse affine (rotate-XOR with constant 0x05);
  - then the multiplicative inverse, with 0 mapping to 0.
  - Inversion path: isomorphic map into GF((2^4)^2); compute the norm with `spem` products, square-scale, and XOR; GF(2^4) inversion; two `spem` products for the output halves; inverse isomorphic map back.
  - Arithmetic is mod-2 throughout; no widths grow.
- `in_valid` is ignored outside IDLE. Upstream must hold `in_state` only for the accept cycle.
- No input/output bypass: a new state is not accepted in the cycle the result is consumed.
- `rst`=1 at any time, including mid-BUSY or in DONE, gives on the next edge:
  - state IDLE, `cnt`=0;
  - working register and `out_state` = 0;
  - `out_valid`=0, `in_ready`=1.
  - Any in-flight state is discarded.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_state`=128'h0.
- Latency: `out_valid` rises exactly N edges after the accept edge:
  - 16 edges for `BYTES_PER_CYCLE`=1;
  - 4 edges for the default;
  - 1 edge for `BYTES_PER_CYCLE`=16.
- `in_ready` drops on the accept edge and returns on the edge after `out_valid && out_ready`.
- Throughput with `out_ready` held high: one state per N+2 cycles.
- `out_state` and `out_valid` are driven directly from registers, with no combinational path from any input.
- Critical path: one per-byte inverse-S-box cone. It is replicated `BYTES_PER_CYCLE` times in parallel, not chained.

## Structure

- Shared package `aes_pkg` holds:
  - the isomorphism matrix and its inverse (the same matrices the forward S-box uses);
  - the GF(2^4) square-scale constant;
  - the inverse affine constant 8'h05;
  - the FSM enum `inv_sb_state_t` {IDLE, BUSY, DONE}.
- Sub-module `aes_inv_sbox_byte`:
  - combinational, 8-bit in / 8-bit out;
  - instantiates three `spem` plus a GF(2^4) inverter.
- Top level contains:
  - the FSM and `cnt`;
  - the working register;
  - a generate loop of `BYTES_PER_CYCLE` `aes_inv_sbox_byte` instances, muxed by `cnt`.

## Test plan

- All-0x63 input:
  - `in_state`=128'h6363…63 with `out_ready`=1 → `out_state`=128'h0.
  - `out_valid` rises exactly 4 edges after accept (default parameter).
- Known-value vector: `in_state` bytes {0x00, 0x7C, 0x16, 0xED, 0x63, …} → bytes {0x52, 0x01, 0xFF, 0x53, 0x00, …}.
  - Sweep all 256 byte values across 16 states and compare against a reference inverse S-box table.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles after `out_valid` → `out_state` stable, `in_ready`=0;
  - a new `in_valid` pulse during that window is ignored;
  - release → back to IDLE one edge later.
- Back-to-back inputs with `in_valid` held high → states accepted every N+2 cycles, results in order.
- Mid-operation reset: assert `rst` during BUSY at `cnt`=2 → the next edge shows `out_valid`=0, `in_ready`=1, `out_state`=0. The following state then processes correctly.
- Parameter sweep over `BYTES_PER_CYCLE` ∈ {1, 2, 4, 8, 16} → identical results; latency 16, 8, 4, 2, 1 edges respectively.
